id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 16-bit MIPS-style CPU. It sits directly upstream of the ALU and registers decoded operands and control from the decode stage. It resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, and presents the final `a`, `b` and `ctrl` values to the ALU. It also detects load-use hazards and inserts bubbles. It honours pipeline stall and flush.

## Interface
- `WIDTH`, 16, datapath width; matches the ALU operand width.
- `RA_W`, 4, register address width; register 0 is hardwired zero.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: downstream stall; EX entry must hold.
- `flush` in 1: kill the EX entry (branch/jump redirect).
- `id_valid` in 1: decode stage presents a valid instruction.
- `id_rs`, `id_rt` in RA_W: source register addresses.
- `id_rd1`, `id_rd2` in WIDTH: register-file read data for rs and rt.
- `id_imm` in WIDTH: sign-extended immediate or shift amount.
- `id_alusrc` in 1: 1 = ALU b comes from the immediate.
- `id_uses_rt` in 1: instruction reads rt as a source (used for hazard detection).
- `id_alu_ctrl` in 3: ALU operation code.
- `id_wreg` in RA_W: destination register.
- `id_regwrite` in 1: instruction writes the register file.
- `id_memread` in 1: instruction is a load.
- `exm_regwrite` in 1, `exm_wreg` in RA_W, `exm_result` in WIDTH: EX/MEM forwarding source.
- `mwb_regwrite` in 1, `mwb_wreg` in RA_W, `mwb_data` in WIDTH: MEM/WB forwarding source.
- `alu_a`, `alu_b` out WIDTH: ALU operands.
- `alu_ctrl` out 3: ALU operation code.
- `ex_store_data` out WIDTH: forwarded rt value, used for stores.
- `ex_valid` out 1: EX entry is valid.
- `ex_wreg` out RA_W: destination register of the EX entry.
- `ex_regwrite` out 1: EX entry writes the register file.
- `ex_memread` out 1: EX entry is a load.
- `ld_use` out 1: load-use hazard; decode must hold its instruction this cycle.

## Operation
- **Stored fields:** valid, rs, rt, rd1, rd2, imm, alusrc, alu_ctrl, wreg, regwrite, memread.
- **Per-edge update, highest priority first:**
  - `reset`: all fields are cleared to 0.
  - `flush`: valid, regwrite and memread are cleared; other fields are don't-care. Flush wins over stall.
  - `stall`: all fields hold, except rd1/rd2, which reload with the current forwarded rs/rt values. This keeps a MEM/WB value that retires during the stall.
  - `ld_use`: a bubble is loaded; all fields are cleared.
  - Otherwise: all fields load from the `id_*` inputs. valid takes the value of `id_valid`.
- **Forwarding (combinational, from the stored fields):**
  - `fwd(r, d)` = `exm_result` if `exm_regwrite` and `exm_wreg`==r and r!=0.
  - Else `mwb_data` if `mwb_regwrite` and `mwb_wreg`==r and r!=0.
  - Else d.
  - EX/MEM has priority over MEM/WB.
- **Outputs:**
  - `alu_a` = fwd(rs, rd1).
  - `ex_store_data` = fwd(rt, rd2).
  - `alu_b` = alusrc ? imm : fwd(rt, rd2).
  - `alu_ctrl` = stored alu_ctrl.
- **Gating:** `ex_regwrite` and `ex_memread` are ANDed with `ex_valid`.
- **Load-use detection:**
  - `ld_use` = `ex_valid` & `ex_memread` & `ex_wreg`!=0 & `id_valid`, ANDed with the match term below.
  - Match term: (`ex_wreg`==`id_rs`) | (`id_uses_rt` & `ex_wreg`==`id_rt`).
  - Computed regardless of `stall`; it has no state effect while stall or flush is asserted.
- **Widths:** all data paths are WIDTH bits; no extension or truncation is performed in this block.

## Timing
- Reset values:
  - `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_wreg` = 0; `alu_ctrl` = 3'b000.
  - `alu_a`, `alu_b`, `ex_store_data` = 0 when no forwarding source matches.
  - `ld_use` = 0.
- ID to ALU-input latency is 1 cycle.
- Forwarding and `ld_use` are combinational, with same-cycle response to the `exm_*`, `mwb_*` and `id_*` inputs.
- Load-use sequence:
  - Cycle N: `ld_use`=1. Decode holds its instruction; this block loads a bubble.
  - Cycle N+1: the load has moved to MEM; the dependent instruction loads at the N+1 edge.
  - Its operand is forwarded from MEM/WB at N+2.
- Reset or flush asserted during a stall clears the entry on that edge.
- Back-to-back valid instructions are accepted every cycle with no bubbles unless `ld_use` fires.

## Test plan
1. **Reset:** reset for 2 cycles with random `id_*` inputs -> `ex_valid`=0, `ex_regwrite`=0, `alu_ctrl`=000, `alu_a`=`alu_b`=0.
2. **Basic load:** id rs=1, rt=2, rd1=0x0005, rd2=0x0003, ctrl=010, alusrc=0, no forwarding -> next cycle `alu_a`=0x0005, `alu_b`=0x0003, `alu_ctrl`=010, `ex_valid`=1.
3. **Forward priority:**
   - EX rs=3 with rd1=0x1111; `exm` (wreg=3, regwrite=1, result=0xAAAA) and `mwb` (wreg=3, data=0xBBBB) both match -> `alu_a`=0xAAAA.
   - Drop `exm_regwrite` -> `alu_a`=0xBBBB.
   - Set rs=0 with both sources targeting reg 0 -> `alu_a`=rd1.
4. **Load-use:**
   - EX holds a load with wreg=4; id rs=4 -> `ld_use`=1; next cycle `ex_valid`=0.
   - Repeat with id_uses_rt=0 and rt=4 -> `ld_use`=0.
5. **Stall refresh:**
   - EX rs=5, `mwb` wreg=5, data=0x00F0, `stall`=1.
   - Next cycle `mwb_regwrite`=0 -> `alu_a` still 0x00F0 and ctrl/valid unchanged.
6. **Flush vs stall:** `flush`=1 and `stall`=1 together on a valid entry -> next cycle `ex_valid`=0, `ex_regwrite`=0, `ex_memread`=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 16-bit MIPS-style CPU.
// Holds the decoded instruction for the EX stage, forwards results from
// EX/MEM and MEM/WB into the ALU operands, and raises ld_use when the
// instruction in decode depends on a load that is currently in EX.

module id_ex_stage #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_alusrc,
    input  logic             id_uses_rt,
    input  logic [2:0]       id_alu_ctrl,
    input  logic [RA_W-1:0]  id_wreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             exm_regwrite,
    input  logic [RA_W-1:0]  exm_wreg,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             mwb_regwrite,
    input  logic [RA_W-1:0]  mwb_wreg,
    input  logic [WIDTH-1:0] mwb_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] ex_store_data,
    output logic             ex_valid,
    output logic [RA_W-1:0]  ex_wreg,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ld_use
);

    logic             valid_q,    valid_d;
    logic [RA_W-1:0]  rs_q,       rs_d;
    logic [RA_W-1:0]  rt_q,       rt_d;
    logic [WIDTH-1:0] rd1_q,      rd1_d;
    logic [WIDTH-1:0] rd2_q,      rd2_d;
    logic [WIDTH-1:0] imm_q,      imm_d;
    logic             aluSrc_q,   aluSrc_d;
    logic [2:0]       aluCtrl_q,  aluCtrl_d;
    logic [RA_W-1:0]  wreg_q,     wreg_d;
    logic             regWrite_q, regWrite_d;
    logic             memRead_q,  memRead_d;

    logic [WIDTH-1:0] fwdA;
    logic [WIDTH-1:0] fwdB;
    logic             ldUseHit;

    // Forwarding mux: the younger EX/MEM result beats MEM/WB, and register 0
    // never forwards because it is hardwired to zero.
    function automatic logic [WIDTH-1:0] fwdSel(
        input logic [RA_W-1:0]  r,
        input logic [WIDTH-1:0] d,
        input logic             exmWe,
        input logic [RA_W-1:0]  exmReg,
        input logic [WIDTH-1:0] exmVal,
        input logic             mwbWe,
        input logic [RA_W-1:0]  mwbReg,
        input logic [WIDTH-1:0] mwbVal
    );
        if (exmWe && (exmReg == r) && (r != '0)) begin
            return exmVal;
        end else if (mwbWe && (mwbReg == r) && (r != '0)) begin
            return mwbVal;
        end else begin
            return d;
        end
    endfunction

    // Forwarded source operands of the entry currently in EX.
    always_comb begin
        fwdA = fwdSel(rs_q, rd1_q, exm_regwrite, exm_wreg, exm_result,
                      mwb_regwrite, mwb_wreg, mwb_data);
        fwdB = fwdSel(rt_q, rd2_q, exm_regwrite, exm_wreg, exm_result,
                      mwb_regwrite, mwb_wreg, mwb_data);
    end

    // Load-use detection: a valid load in EX whose destination is read by
    // the instruction waiting in decode.
    always_comb begin
        ldUseHit = valid_q && memRead_q && (wreg_q != '0) && id_valid &&
                   ((wreg_q == id_rs) || (id_uses_rt && (wreg_q == id_rt)));
    end

    // Next-state selection: flush beats stall, stall beats the bubble, and
    // a stall refreshes rd1/rd2 so a MEM/WB value retiring mid-stall is kept.
    always_comb begin
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        aluSrc_d   = aluSrc_q;
        aluCtrl_d  = aluCtrl_q;
        wreg_d     = wreg_q;
        regWrite_d = regWrite_q;
        memRead_d  = memRead_q;
        if (flush) begin
            valid_d    = 1'b0;
            regWrite_d = 1'b0;
            memRead_d  = 1'b0;
        end else if (stall) begin
            rd1_d = fwdA;
            rd2_d = fwdB;
        end else if (ldUseHit) begin
            valid_d    = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            aluSrc_d   = 1'b0;
            aluCtrl_d  = 3'b000;
            wreg_d     = '0;
            regWrite_d = 1'b0;
            memRead_d  = 1'b0;
        end else begin
            valid_d    = id_valid;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd1_d      = id_rd1;
            rd2_d      = id_rd2;
            imm_d      = id_imm;
            aluSrc_d   = id_alusrc;
            aluCtrl_d  = id_alu_ctrl;
            wreg_d     = id_wreg;
            regWrite_d = id_regwrite;
            memRead_d  = id_memread;
        end
    end

    // Pipeline register with synchronous reset clearing every field.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            aluSrc_q   <= 1'b0;
            aluCtrl_q  <= 3'b000;
            wreg_q     <= '0;
            regWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            aluSrc_q   <= aluSrc_d;
            aluCtrl_q  <= aluCtrl_d;
            wreg_q     <= wreg_d;
            regWrite_q <= regWrite_d;
            memRead_q  <= memRead_d;
        end
    end

    // ALU-facing outputs; write and load flags only count for a valid entry.
    always_comb begin
        alu_a         = fwdA;
        ex_store_data = fwdB;
        alu_b         = aluSrc_q ? imm_q : fwdB;
        alu_ctrl      = aluCtrl_q;
        ex_valid      = valid_q;
        ex_wreg       = wreg_q;
        ex_regwrite   = valid_q & regWrite_q;
        ex_memread    = valid_q & memRead_q;
        ld_use        = ldUseHit;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test of the ID/EX stage. Stimulus pushes the
// expected output values into a queue; a monitor pops and compares them on
// the falling edge, halfway between input changes and the next rising edge.

module tb_id_ex_stage;

    localparam int WIDTH = 16;
    localparam int RA_W  = 4;

    localparam int S_A     = 0;
    localparam int S_B     = 1;
    localparam int S_CTRL  = 2;
    localparam int S_STORE = 3;
    localparam int S_VALID = 4;
    localparam int S_WREG  = 5;
    localparam int S_RW    = 6;
    localparam int S_MR    = 7;
    localparam int S_LDUSE = 8;

    typedef struct {
        string       name;
        int          sig;
        logic [15:0] exp;
    } sbEntry_t;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             flush;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic [WIDTH-1:0] id_rd1;
    logic [WIDTH-1:0] id_rd2;
    logic [WIDTH-1:0] id_imm;
    logic             id_alusrc;
    logic             id_uses_rt;
    logic [2:0]       id_alu_ctrl;
    logic [RA_W-1:0]  id_wreg;
    logic             id_regwrite;
    logic             id_memread;
    logic             exm_regwrite;
    logic [RA_W-1:0]  exm_wreg;
    logic [WIDTH-1:0] exm_result;
    logic             mwb_regwrite;
    logic [RA_W-1:0]  mwb_wreg;
    logic [WIDTH-1:0] mwb_data;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] ex_store_data;
    logic             ex_valid;
    logic [RA_W-1:0]  ex_wreg;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ld_use;

    sbEntry_t sbQ[$];
    int       checkCount = 0;
    int       errorCount = 0;

    id_ex_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_uses_rt(id_uses_rt),
        .id_alu_ctrl(id_alu_ctrl), .id_wreg(id_wreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .exm_regwrite(exm_regwrite), .exm_wreg(exm_wreg), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_wreg(mwb_wreg), .mwb_data(mwb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ld_use(ld_use)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] getActual(input int sig);
        case (sig)
            S_A:     return alu_a;
            S_B:     return alu_b;
            S_CTRL:  return {13'b0, alu_ctrl};
            S_STORE: return ex_store_data;
            S_VALID: return {15'b0, ex_valid};
            S_WREG:  return {12'b0, ex_wreg};
            S_RW:    return {15'b0, ex_regwrite};
            S_MR:    return {15'b0, ex_memread};
            S_LDUSE: return {15'b0, ld_use};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Monitor: drain every pending expectation against the live outputs.
    always @(negedge clk) begin
        while (sbQ.size() > 0) begin
            sbEntry_t e;
            logic [15:0] act;
            e   = sbQ.pop_front();
            act = getActual(e.sig);
            checkCount++;
            if (act !== e.exp) begin
                errorCount++;
                $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", e.name, act, e.exp);
            end
        end
    end

    task automatic checkOutput(input string name, input int sig, input logic [15:0] exp);
        sbEntry_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sbQ.push_back(e);
    endtask

    // One rising edge, then let inputs settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        stall = 0; flush = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_alusrc = 0; id_uses_rt = 0; id_alu_ctrl = 0; id_wreg = 0;
        id_regwrite = 0; id_memread = 0;
        exm_regwrite = 0; exm_wreg = 0; exm_result = 0;
        mwb_regwrite = 0; mwb_wreg = 0; mwb_data = 0;
    endtask

    task automatic randomId();
        id_valid = 1'($urandom); id_rs = 4'($urandom); id_rt = 4'($urandom);
        id_rd1 = 16'($urandom); id_rd2 = 16'($urandom); id_imm = 16'($urandom);
        id_alusrc = 1'($urandom); id_uses_rt = 1'($urandom);
        id_alu_ctrl = 3'($urandom); id_wreg = 4'($urandom);
        id_regwrite = 1'($urandom); id_memread = 1'($urandom);
    endtask

    task automatic loadLoad(input logic [RA_W-1:0] wreg, input logic [RA_W-1:0] rs);
        clearInputs();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_wreg = wreg;
        id_rs = rs; id_rd1 = 16'h0010; id_alusrc = 1; id_imm = 16'h0008;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clearInputs();
        reset = 1;

        // Reset with random decode inputs
        randomId();
        applyStimulus();
        checkOutput("rst1_valid", S_VALID, 0);
        checkOutput("rst1_rw",    S_RW,    0);
        checkOutput("rst1_ctrl",  S_CTRL,  0);
        randomId();
        applyStimulus();
        checkOutput("rst2_valid", S_VALID, 0);
        checkOutput("rst2_rw",    S_RW,    0);
        checkOutput("rst2_mr",    S_MR,    0);
        checkOutput("rst2_ctrl",  S_CTRL,  0);
        checkOutput("rst2_a",     S_A,     0);
        checkOutput("rst2_b",     S_B,     0);
        checkOutput("rst2_wreg",  S_WREG,  0);
        checkOutput("rst2_lduse", S_LDUSE, 0);

        // Basic load
        clearInputs();
        reset = 0;
        id_valid = 1; id_rs = 1; id_rt = 2; id_rd1 = 16'h0005; id_rd2 = 16'h0003;
        id_alu_ctrl = 3'b010; id_regwrite = 1; id_wreg = 6;
        applyStimulus();
        checkOutput("basic_a",     S_A,     16'h0005);
        checkOutput("basic_b",     S_B,     16'h0003);
        checkOutput("basic_ctrl",  S_CTRL,  16'h0002);
        checkOutput("basic_valid", S_VALID, 1);
        checkOutput("basic_rw",    S_RW,    1);
        checkOutput("basic_store", S_STORE, 16'h0003);
        checkOutput("basic_wreg",  S_WREG,  6);

        // Back-to-back immediate instruction
        id_rs = 1; id_rd1 = 16'h0007; id_rt = 2; id_rd2 = 16'h0009;
        id_imm = 16'h0040; id_alusrc = 1; id_alu_ctrl = 3'b001;
        applyStimulus();
        checkOutput("imm_a",     S_A,     16'h0007);
        checkOutput("imm_b",     S_B,     16'h0040);
        checkOutput("imm_store", S_STORE, 16'h0009);
        checkOutput("imm_ctrl",  S_CTRL,  16'h0001);

        // Forward priority
        clearInputs();
        id_valid = 1; id_rs = 3; id_rd1 = 16'h1111; id_rt = 0; id_rd2 = 16'h2222;
        id_alu_ctrl = 3'b011;
        applyStimulus();
        clearInputs();
        stall = 1;
        exm_regwrite = 1; exm_wreg = 3; exm_result = 16'hAAAA;
        mwb_regwrite = 1; mwb_wreg = 3; mwb_data = 16'hBBBB;
        checkOutput("fwd_exm_a", S_A,    16'hAAAA);
        checkOutput("fwd_exm_b", S_B,    16'h2222);
        checkOutput("fwd_ctrl",  S_CTRL, 16'h0003);
        applyStimulus();
        exm_regwrite = 0;
        checkOutput("fwd_mwb_a", S_A, 16'hBBBB);
        applyStimulus();
        stall = 0;
        exm_regwrite = 1; exm_wreg = 0;
        mwb_regwrite = 1; mwb_wreg = 0;
        id_valid = 1; id_rs = 0; id_rt = 0; id_rd1 = 16'h1234; id_rd2 = 16'h0055;
        id_alu_ctrl = 3'b100;
        applyStimulus();
        checkOutput("fwd_r0_a", S_A, 16'h1234);
        checkOutput("fwd_r0_b", S_B, 16'h0055);

        // Load-use on rs
        clearInputs();
        applyStimulus();
        loadLoad(4, 1);
        applyStimulus();
        checkOutput("lu_load_mr", S_MR, 1);
        clearInputs();
        id_valid = 1; id_rs = 4; id_rt = 5; id_uses_rt = 1; id_regwrite = 1;
        id_wreg = 7; id_rd1 = 16'h0099;
        checkOutput("lu_rs_hit", S_LDUSE, 1);
        applyStimulus();
        checkOutput("lu_bub_valid", S_VALID, 0);
        checkOutput("lu_bub_rw",    S_RW,    0);
        checkOutput("lu_bub_mr",    S_MR,    0);
        checkOutput("lu_bub_lduse", S_LDUSE, 0);
        checkOutput("lu_bub_a",     S_A,     0);
        applyStimulus();
        checkOutput("lu_dep_valid", S_VALID, 1);
        checkOutput("lu_dep_a",     S_A,     16'h0099);
        checkOutput("lu_dep_wreg",  S_WREG,  7);

        // rt match ignored when rt is not a source
        loadLoad(4, 1);
        applyStimulus();
        clearInputs();
        id_valid = 1; id_rs = 2; id_rt = 4; id_uses_rt = 0; id_rd1 = 16'h0021;
        id_rd2 = 16'h0022; id_alu_ctrl = 3'b101; id_wreg = 8; id_regwrite = 1;
        checkOutput("lu_rt_unused", S_LDUSE, 0);
        applyStimulus();
        checkOutput("lu_rt_valid", S_VALID, 1);
        checkOutput("lu_rt_a",     S_A,     16'h0021);
        checkOutput("lu_rt_ctrl",  S_CTRL,  16'h0005);

        // rt match counts when rt is a source
        loadLoad(4, 1);
        applyStimulus();
        clearInputs();
        id_valid = 1; id_rs = 2; id_rt = 4; id_uses_rt = 1;
        checkOutput("lu_rt_used", S_LDUSE, 1);
        applyStimulus();

        // Load targeting register 0 never stalls
        loadLoad(0, 0);
        applyStimulus();
        clearInputs();
        id_valid = 1; id_rs = 0;
        checkOutput("lu_r0_mr",    S_MR,    1);
        checkOutput("lu_r0_lduse", S_LDUSE, 0);
        applyStimulus();

        // Stall refresh keeps a retiring MEM/WB value
        clearInputs();
        applyStimulus();
        id_valid = 1; id_rs = 5; id_rd1 = 16'h0007; id_alu_ctrl = 3'b110;
        id_regwrite = 1; id_wreg = 9;
        applyStimulus();
        clearInputs();
        stall = 1;
        mwb_regwrite = 1; mwb_wreg = 5; mwb_data = 16'h00F0;
        id_valid = 1; id_rs = 1; id_rd1 = 16'h3333; id_alu_ctrl = 3'b001;
        checkOutput("stall_fwd_a", S_A, 16'h00F0);
        applyStimulus();
        mwb_regwrite = 0;
        checkOutput("stall_hold_a",     S_A,     16'h00F0);
        checkOutput("stall_hold_ctrl",  S_CTRL,  16'h0006);
        checkOutput("stall_hold_valid", S_VALID, 1);
        checkOutput("stall_hold_wreg",  S_WREG,  9);
        applyStimulus();
        checkOutput("stall_hold2_a", S_A, 16'h00F0);

        // Flush beats stall
        loadLoad(3, 1);
        applyStimulus();
        checkOutput("flush_pre_mr", S_MR, 1);
        clearInputs();
        flush = 1; stall = 1; id_valid = 1; id_rs = 2;
        applyStimulus();
        checkOutput("flush_valid", S_VALID, 0);
        checkOutput("flush_rw",    S_RW,    0);
        checkOutput("flush_mr",    S_MR,    0);

        // Reset during stall clears the entry
        clearInputs();
        id_valid = 1; id_regwrite = 1; id_wreg = 2; id_alu_ctrl = 3'b111;
        applyStimulus();
        checkOutput("rststall_pre_ctrl", S_CTRL, 16'h0007);
        stall = 1; reset = 1;
        applyStimulus();
        reset = 0;
        checkOutput("rststall_valid", S_VALID, 0);
        checkOutput("rststall_rw",    S_RW,    0);
        checkOutput("rststall_ctrl",  S_CTRL,  0);

        @(negedge clk);
        @(negedge clk);
        if (sbQ.size() > 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
            errorCount += sbQ.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
